softmax_max_scan: RTL and testbench
===================================

Name: softmax_max_scan

Overview:
- Sequencer and running-max stage that sits directly upstream of the 100-to-1 element mux and consumes its output.
- On a start pulse it drives the mux select through indices 1..NUM_ELEM, one per cycle, and samples the selected element each cycle.
- It returns the maximum element and its 1-based index, for use by the softmax subtract-max/exp stage.

Parameters:
- DATA_WIDTH, 16, width of each element and of max_o.
- NUM_ELEM, 100, number of elements scanned. Legal range 1..100.
- SIGNED_CMP, 1, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  single-cycle request to begin a scan; sampled only in IDLE and DONE.
- mux_data_i  input  DATA_WIDTH  element returned by the mux for the current sel_o, same cycle (combinational path).
- sel_o  output  7  mux select. 0 = idle (mux drives zero); 1..NUM_ELEM during a scan.
- busy_o  output  1  high while scanning.
- done_o  output  1  one-cycle pulse when max_o/max_idx_o are updated.
- max_o  output  DATA_WIDTH  maximum element of the last completed scan.
- max_idx_o  output  7  1-based index of max_o.

Behaviour:
- Reset (asynchronous, active-high) forces: state=IDLE, sel_o=0, busy_o=0, done_o=0, max_o=0, max_idx_o=0, internal run_max=0, run_idx=0.
- Reset asserted mid-scan aborts the scan. Outputs return to their reset values and there is no done pulse.
- States and transitions:
  - IDLE: sel_o=0, busy_o=0. start_i=1 -> SCAN, sel_o<=1, busy_o<=1.
  - SCAN: each cycle, sample mux_data_i for index sel_o.
    - If sel_o==1, load run_max<=mux_data_i and run_idx<=1 unconditionally.
    - Otherwise, if mux_data_i > run_max (strict, per SIGNED_CMP), update run_max and run_idx<=sel_o.
    - If sel_o<NUM_ELEM: sel_o<=sel_o+1.
    - If sel_o==NUM_ELEM: -> DONE. sel_o<=0, busy_o<=0, done_o<=1. max_o and max_idx_o load the final comparison result, including the last element.
    - start_i is ignored in SCAN.
  - DONE: lasts one cycle; done_o=1 there. done_o<=0 next cycle. start_i=1 in DONE -> SCAN directly (back-to-back scans); otherwise -> IDLE.
- Latency: start_i sampled at edge 0. sel_o=k during cycle k (k=1..NUM_ELEM). done_o is high in cycle NUM_ELEM+1. Total NUM_ELEM+1 cycles from start to done.
- Ties: the lowest index wins (strict greater-than).
- NUM_ELEM=1: one SCAN cycle, then DONE with max_idx_o=1.
- max_o and max_idx_o hold their values until the next done. They are not cleared by start.
- sel_o never takes values above NUM_ELEM; the counter never wraps.
- All outputs are registered. The only combinational dependency is the compare on mux_data_i.

Decomposition:
- Shared softmax package holds:
  - state enum {IDLE, SCAN, DONE}
  - SEL_W=7
  - MAX_ELEM=100
  - default DATA_WIDTH=16
- One natural sub-module, softmax_cmp_gt: a combinational greater-than with a SIGNED_CMP parameter. It will be reused by later softmax stages. Everything else lives in this block.

Test Plan:
- Reset mid-scan: start, then assert rst during cycle 40 -> sel_o=0, busy_o=0, max_o=0 immediately (async). No done_o afterwards.
- Ascending data: element k=k, NUM_ELEM=100, signed -> done_o in cycle 101, max_o=100, max_idx_o=100. sel_o steps 1..100 exactly once.
- Signed negatives: all elements = -5 except element 37 = -1 -> max_o=16'hFFFF, max_idx_o=37. Same data with SIGNED_CMP=0 -> max_o=16'hFFFF, max_idx_o=37. With element 12 = 16'h7FFF and SIGNED_CMP=1 -> max_idx_o=12.
- Ties: elements 5 and 80 both = 1000, all others 0 -> max_idx_o=5.
- Back-to-back: start_i held high in the DONE cycle -> sel_o=1 in the next cycle, busy_o=1. Second result correct. The first result stays visible until the second done.
- Edge config: NUM_ELEM=1, element1=16'h1234 -> done_o in cycle 2, max_o=16'h1234, max_idx_o=1. start_i pulses during SCAN are ignored (done count stays at 1).

Source files
------------

// File: rtl/softmax_max_scan_pkg.sv
// Shared softmax definitions: scan sequencer states and sizing constants.
package softmax_max_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SEL_W              = 7;
    localparam int MAX_ELEM           = 100;
    localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/softmax_cmp_gt.sv
// Combinational strict greater-than, signed or unsigned by parameter.
module softmax_cmp_gt #(
    parameter int DATA_WIDTH = 16,
    parameter int SIGNED_CMP = 1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  gt
);

    always_comb begin
        gt = 1'b0;
        if (SIGNED_CMP != 0) begin
            gt = ($signed(a) > $signed(b));
        end else begin
            gt = (a > b);
        end
    end

endmodule

// File: rtl/softmax_max_scan.sv
// Drives the element mux select 1..NUM_ELEM and tracks the running maximum
// and its 1-based index; publishes the result with a one-cycle done pulse.
module softmax_max_scan
    import softmax_max_scan_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_ELEM   = 100,
    parameter int SIGNED_CMP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] mux_data_i,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] max_o,
    output logic [SEL_W-1:0]      max_idx_o
);

    if (NUM_ELEM < 1 || NUM_ELEM > MAX_ELEM) begin : g_bad_num_elem
        $error("softmax_max_scan: NUM_ELEM out of range 1..%0d", MAX_ELEM);
    end

    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_ELEM);
    localparam logic [SEL_W-1:0] FIRST_SEL = SEL_W'(1);

    state_t                state;
    logic [DATA_WIDTH-1:0] run_max;
    logic [SEL_W-1:0]      run_idx;
    logic                  data_gt;
    logic                  take;

    softmax_cmp_gt #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
        .a  (mux_data_i),
        .b  (run_max),
        .gt (data_gt)
    );

    // First element always seeds the running max; later ones need strict
    // greater-than so ties keep the lowest index.
    always_comb begin
        take = 1'b0;
        if (sel_o == FIRST_SEL || data_gt) begin
            take = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_o     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            max_o     <= '0;
            max_idx_o <= '0;
            run_max   <= '0;
            run_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state  <= SCAN;
                        sel_o  <= FIRST_SEL;
                        busy_o <= 1'b1;
                    end
                end

                SCAN: begin
                    done_o <= 1'b0;
                    if (take) begin
                        run_max <= mux_data_i;
                        run_idx <= sel_o;
                    end
                    if (sel_o == LAST_SEL) begin
                        // Publish directly from this cycle's compare so the
                        // last element is included without an extra cycle.
                        state     <= DONE;
                        sel_o     <= '0;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        max_o     <= take ? mux_data_i : run_max;
                        max_idx_o <= take ? sel_o : run_idx;
                    end else begin
                        sel_o <= sel_o + FIRST_SEL;
                    end
                end

                DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state  <= SCAN;
                        sel_o  <= FIRST_SEL;
                        busy_o <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    sel_o  <= '0;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_max_scan.sv
// Directed bench for softmax_max_scan: three instances (100 signed,
// 100 unsigned, 1 element) fed from a shared element table.
module tb_softmax_max_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem [0:100];

    logic        start_m, start_u, start_o;
    logic [6:0]  sel_m, sel_u, sel_o1;
    logic        busy_m, busy_u, busy_o1;
    logic        done_m, done_u, done_o1;
    logic [15:0] max_m, max_u, max_o1;
    logic [6:0]  idx_m, idx_u, idx_o1;
    logic [15:0] data_m, data_u, data_o1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign data_m  = (sel_m  <= 7'd100) ? mem[sel_m]  : 16'h0000;
    assign data_u  = (sel_u  <= 7'd100) ? mem[sel_u]  : 16'h0000;
    assign data_o1 = (sel_o1 <= 7'd100) ? mem[sel_o1] : 16'h0000;

    softmax_max_scan #(.DATA_WIDTH(16), .NUM_ELEM(100), .SIGNED_CMP(1)) u_main (
        .clk(clk), .rst(rst), .start_i(start_m), .mux_data_i(data_m),
        .sel_o(sel_m), .busy_o(busy_m), .done_o(done_m), .max_o(max_m), .max_idx_o(idx_m)
    );

    softmax_max_scan #(.DATA_WIDTH(16), .NUM_ELEM(100), .SIGNED_CMP(0)) u_uns (
        .clk(clk), .rst(rst), .start_i(start_u), .mux_data_i(data_u),
        .sel_o(sel_u), .busy_o(busy_u), .done_o(done_u), .max_o(max_u), .max_idx_o(idx_u)
    );

    softmax_max_scan #(.DATA_WIDTH(16), .NUM_ELEM(1), .SIGNED_CMP(1)) u_one (
        .clk(clk), .rst(rst), .start_i(start_o), .mux_data_i(data_o1),
        .sel_o(sel_o1), .busy_o(busy_o1), .done_o(done_o1), .max_o(max_o1), .max_idx_o(idx_o1)
    );

    function automatic logic [6:0] sel_of(input int w);
        return (w == 0) ? sel_m : (w == 1) ? sel_u : sel_o1;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 0) ? done_m : (w == 1) ? done_u : done_o1;
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 0) start_m = v;
        else if (w == 1) start_u = v;
        else start_o = v;
    endtask

    // Pulse start (sampled at edge 0), then step until done; cyc = cycle of done.
    task automatic run_scan(input int w, output int cyc, output bit sel_ok);
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        cyc = 1;
        sel_ok = 1'b1;
        while (!done_of(w) && cyc < 300) begin
            if (sel_of(w) !== 7'(cyc)) sel_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sel_m !== 7'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_m); end
        checks++; if (max_m !== 16'h0000) begin errors++; $display("FAIL reset_max got=%h exp=0000", max_m); end
        checks++; if (idx_m !== 7'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx_m); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ascending();
        int cyc;
        bit ok;
        for (int k = 1; k <= 100; k++) mem[k] = 16'(k);
        run_scan(0, cyc, ok);
        checks++; if (cyc !== 101) begin errors++; $display("FAIL asc_done_cycle got=%0d exp=101", cyc); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL asc_sel_steps got=%b exp=1", ok); end
        checks++; if (max_m !== 16'd100) begin errors++; $display("FAIL asc_max got=%0d exp=100", max_m); end
        checks++; if (idx_m !== 7'd100) begin errors++; $display("FAIL asc_idx got=%0d exp=100", idx_m); end
        checks++; if (busy_m !== 1'b0 || sel_m !== 7'd0) begin
            errors++; $display("FAIL asc_done_idle got busy=%b sel=%0d exp busy=0 sel=0", busy_m, sel_m);
        end
        @(posedge clk); #1;
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL asc_done_pulse got=%b exp=0", done_m); end
    endtask

    task automatic test_signed();
        int cyc;
        bit ok;
        for (int k = 1; k <= 100; k++) mem[k] = 16'hFFFB;
        mem[37] = 16'hFFFF;
        run_scan(0, cyc, ok);
        checks++; if (max_m !== 16'hFFFF || idx_m !== 7'd37) begin
            errors++; $display("FAIL neg_signed got=%h/%0d exp=ffff/37", max_m, idx_m);
        end
        run_scan(1, cyc, ok);
        checks++; if (max_u !== 16'hFFFF || idx_u !== 7'd37) begin
            errors++; $display("FAIL neg_unsigned got=%h/%0d exp=ffff/37", max_u, idx_u);
        end
        mem[12] = 16'h7FFF;
        run_scan(0, cyc, ok);
        checks++; if (max_m !== 16'h7FFF || idx_m !== 7'd12) begin
            errors++; $display("FAIL pos_signed got=%h/%0d exp=7fff/12", max_m, idx_m);
        end
        run_scan(1, cyc, ok);
        checks++; if (max_u !== 16'hFFFF || idx_u !== 7'd37) begin
            errors++; $display("FAIL pos_unsigned got=%h/%0d exp=ffff/37", max_u, idx_u);
        end
    endtask

    task automatic test_ties();
        int cyc;
        bit ok;
        for (int k = 1; k <= 100; k++) mem[k] = 16'h0000;
        mem[5]  = 16'd1000;
        mem[80] = 16'd1000;
        run_scan(0, cyc, ok);
        checks++; if (max_m !== 16'd1000 || idx_m !== 7'd5) begin
            errors++; $display("FAIL ties got=%0d/%0d exp=1000/5", max_m, idx_m);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int cyc2;
        bit ok;
        bit held;
        run_scan(0, cyc, ok);   // tie data still loaded: 1000 at index 5
        checks++; if (done_m !== 1'b1 || idx_m !== 7'd5) begin
            errors++; $display("FAIL b2b_first got done=%b idx=%0d exp done=1 idx=5", done_m, idx_m);
        end
        start_m = 1'b1;
        for (int k = 1; k <= 100; k++) mem[k] = 16'(k);
        @(posedge clk); #1;
        start_m = 1'b0;
        checks++; if (sel_m !== 7'd1 || busy_m !== 1'b1 || done_m !== 1'b0) begin
            errors++; $display("FAIL b2b_restart got sel=%0d busy=%b done=%b exp 1/1/0", sel_m, busy_m, done_m);
        end
        cyc2 = 1;
        held = 1'b1;
        while (!done_m && cyc2 < 300) begin
            if (max_m !== 16'd1000 || idx_m !== 7'd5) held = 1'b0;
            @(posedge clk); #1;
            cyc2++;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold got=%b exp=1", held); end
        checks++; if (cyc2 !== 101) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=101", cyc2); end
        checks++; if (max_m !== 16'd100 || idx_m !== 7'd100) begin
            errors++; $display("FAIL b2b_second got=%0d/%0d exp=100/100", max_m, idx_m);
        end
    endtask

    task automatic test_single_elem();
        int dones;
        mem[1] = 16'h1234;
        start_o = 1'b1;
        @(posedge clk); #1;   // cycle 1: SCAN, start still high and must be ignored
        checks++; if (sel_o1 !== 7'd1 || busy_o1 !== 1'b1 || done_o1 !== 1'b0) begin
            errors++; $display("FAIL one_scan got sel=%0d busy=%b done=%b exp 1/1/0", sel_o1, busy_o1, done_o1);
        end
        @(posedge clk); #1;   // cycle 2: DONE
        start_o = 1'b0;
        checks++; if (done_o1 !== 1'b1) begin errors++; $display("FAIL one_done_cycle got=%b exp=1", done_o1); end
        checks++; if (max_o1 !== 16'h1234 || idx_o1 !== 7'd1) begin
            errors++; $display("FAIL one_result got=%h/%0d exp=1234/1", max_o1, idx_o1);
        end
        dones = 1;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_o1) dones++;
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL one_done_count got=%0d exp=1", dones); end
        checks++; if (sel_o1 !== 7'd0 || busy_o1 !== 1'b0) begin
            errors++; $display("FAIL one_idle got sel=%0d busy=%b exp 0/0", sel_o1, busy_o1);
        end
    endtask

    task automatic test_reset_mid_scan();
        int dones;
        for (int k = 1; k <= 100; k++) mem[k] = 16'(k);
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        checks++; if (sel_m !== 7'd40) begin errors++; $display("FAIL mid_sel40 got=%0d exp=40", sel_m); end
        #2 rst = 1'b1;
        #1;
        checks++; if (sel_m !== 7'd0 || busy_m !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctrl got sel=%0d busy=%b exp 0/0", sel_m, busy_m);
        end
        checks++; if (max_m !== 16'h0000 || idx_m !== 7'd0) begin
            errors++; $display("FAIL mid_rst_result got=%h/%0d exp=0000/0", max_m, idx_m);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (done_m) dones++;
        end
        checks++; if (dones !== 0 || busy_m !== 1'b0) begin
            errors++; $display("FAIL mid_no_done got dones=%0d busy=%b exp 0/0", dones, busy_m);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_m = 1'b0;
        start_u = 1'b0;
        start_o = 1'b0;
        for (int k = 0; k <= 100; k++) mem[k] = 16'h0000;
        test_reset();
        test_ascending();
        test_signed();
        test_ties();
        test_back_to_back();
        test_single_elem();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
